// File: rtl/seg_scan_driver.sv
// seg_scan_driver: binary-to-BCD display driver with multiplexed seven-segment scan.
// A value load runs a sequential double-dabble conversion (one iteration per clock).
// A message load latches raw nibbles directly. The committed nibbles are shown one
// digit at a time on active-low anodes and segments.
// Optional feature: define SEG_LZB_EN to blank leading zeros of committed numeric values.
`timescale 1ns/1ps

module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 8,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    msg_en,
    input  logic [VALUE_W-1:0]      value,
    input  logic [4*NUM_DIGITS-1:0] msg,
    output logic                    ready,
    output logic                    ovf,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    // Number of decimal digits needed to hold 2^w-1.
    function automatic int dec_digits(input int w);
        longint unsigned m;
        int n;
        m = (longint'(1) << w) - 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m != 0) begin
                m = m / 10;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int ACC_DIGITS = (dec_digits(VALUE_W) > NUM_DIGITS) ? dec_digits(VALUE_W) : NUM_DIGITS;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_W);
    localparam int PRE_W      = $clog2(SCAN_DIV);
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [31:0] MAX_DISP = 32'(pow10(NUM_DIGITS) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
    function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef SEG_LZB_EN
    // Replace zero digits above the highest non-zero digit with blank; digit 0 always shows.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic lead;
        r    = d;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (d[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
        return r;
    endfunction
`endif

    // Active-high gfedcba pattern for one nibble code.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h50;
            4'hB: seg_decode = 7'h54;
            4'hC: seg_decode = 7'h5C;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    state_t               state, state_next;
    logic [CNT_W-1:0]     iter;
    logic                 ovf_pending;
    logic [VALUE_W-1:0]   sreg;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_adj;
    logic [BCD_W-1:0]     commit_bcd;
    logic                 value_over;
    logic                 accept_value;
    logic [PRE_W-1:0]     presc;
    logic [IDX_W-1:0]     idx;
    logic [3:0]           cur_digit;
    logic [NUM_DIGITS-1:0] an_next;

    assign acc_adj      = add3_digits(acc);
    assign value_over   = ({{(32-VALUE_W){1'b0}}, value} > MAX_DISP);
    assign accept_value = (state == IDLE) && load && !msg_en;

`ifdef SEG_LZB_EN
    assign commit_bcd = ovf_pending ? {NUM_DIGITS{4'hE}} : blank_leading(acc[BCD_W-1:0]);
`else
    assign commit_bcd = ovf_pending ? {NUM_DIGITS{4'hE}} : acc[BCD_W-1:0];
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state and ready output.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load && !msg_en) state_next = CONV;
            end
            CONV: begin
                if (iter == CNT_W'(VALUE_W - 1)) state_next = COMMIT;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control: iteration count, pending overflow, committed nibbles and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter        <= '0;
            ovf_pending <= 1'b0;
            bcd         <= {NUM_DIGITS{4'hF}};
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && msg_en) begin
                        bcd <= msg;
                        ovf <= 1'b0;
                    end else if (load) begin
                        iter        <= '0;
                        ovf_pending <= value_over;
                    end
                end
                CONV:   iter <= iter + 1'b1;
                COMMIT: begin
                    bcd <= commit_bcd;
                    ovf <= ovf_pending;
                end
                default: ;
            endcase
        end
    end

    // Conversion datapath: shift register and BCD accumulator.
    always_ff @(posedge clk) begin
        if (accept_value) begin
            sreg <= value;
            acc  <= '0;
        end else if (state == CONV) begin
            acc  <= {acc_adj[ACC_W-2:0], sreg[VALUE_W-1]};
            sreg <= {sreg[VALUE_W-2:0], 1'b0};
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Select the active digit nibble and its one-hot anode.
    always_comb begin
        cur_digit = 4'hF;
        an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit  = bcd[4*i +: 4];
                an_next[i] = 1'b0;
            end
        end
    end

    // Registered pin drivers: anode and segment change together, no blanking gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            seg <= 7'h7F;
        end else begin
            an  <= an_next;
            seg <= ~seg_decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver: a 4-digit instance and a 2-digit instance
// for overflow. Expected display contents come from an arithmetic decimal model.
`timescale 1ns/1ps

module tb_seg_scan_driver;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        load_a, msg_en_a;
    logic [7:0]  value_a;
    logic [15:0] msg_a;
    logic        ready_a, ovf_a;
    logic [15:0] bcd_a;
    logic [3:0]  an_a;
    logic [6:0]  seg_a;

    logic        load_b, msg_en_b;
    logic [7:0]  value_b;
    logic [7:0]  msg_b;
    logic        ready_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  an_b;
    logic [6:0]  seg_b;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(4), .VALUE_W(8), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .load(load_a), .msg_en(msg_en_a), .value(value_a),
        .msg(msg_a), .ready(ready_a), .ovf(ovf_a), .bcd(bcd_a), .an(an_a), .seg(seg_a)
    );

    seg_scan_driver #(.NUM_DIGITS(2), .VALUE_W(8), .SCAN_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .load(load_b), .msg_en(msg_en_b), .value(value_b),
        .msg(msg_b), .ready(ready_b), .ovf(ovf_b), .bcd(bcd_b), .an(an_b), .seg(seg_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal display model: digits by division, overflow shows all E.
    function automatic exp_t model(input int v, input int nd);
        exp_t r;
        int lim, t;
        logic lead;
        r   = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (v > lim - 1) begin
            for (int i = 0; i < nd; i++) r.bcd[4*i +: 4] = 4'hE;
            r.ovf = 1'b1;
        end else begin
            t = v;
            for (int i = 0; i < nd; i++) begin
                r.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
`ifdef SEG_LZB_EN
            lead = 1'b1;
            for (int i = nd - 1; i >= 1; i--) begin
                if (lead && r.bcd[4*i +: 4] == 4'h0) r.bcd[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
            r.ovf = lead & 1'b0;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h50; 4'hB: p = 7'h54;
            4'hC: p = 7'h5C; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h00;
        endcase
        return ~p;
    endfunction

    // Value load with scoreboard; optionally tries a second load during conversion.
    task automatic do_value(input bit on_b, input int v, input bit inject);
        int   cycles;
        exp_t e;
        logic rdy;
        sb.push_back(model(v, on_b ? 2 : 4));
        if (on_b) begin load_b = 1'b1; msg_en_b = 1'b0; value_b = 8'(v); end
        else      begin load_a = 1'b1; msg_en_a = 1'b0; value_a = 8'(v); end
        @(posedge clk); #1;
        load_a = 1'b0; load_b = 1'b0;
        rdy = on_b ? ready_b : ready_a;
        check("ready_drop", {31'd0, rdy}, 32'd0);
        cycles = 0;
        while (!rdy && cycles < 50) begin
            if (inject && cycles == 3) begin
                if (on_b) begin load_b = 1'b1; value_b = 8'd5; end
                else      begin load_a = 1'b1; value_a = 8'd5; end
            end else begin
                load_a = 1'b0; load_b = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            rdy = on_b ? ready_b : ready_a;
        end
        load_a = 1'b0; load_b = 1'b0;
        check("busy_cycles", cycles, 32'd9);
        e = sb.pop_front();
        if (on_b) begin
            check("bcd_b", {24'd0, bcd_b}, {16'd0, e.bcd});
            check("ovf_b", {31'd0, ovf_b}, {31'd0, e.ovf});
        end else begin
            check("bcd_a", {16'd0, bcd_a}, {16'd0, e.bcd});
            check("ovf_a", {31'd0, ovf_a}, {31'd0, e.ovf});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   k, waitc;
        logic [3:0] exp_an;
        rst = 1'b1;
        load_a = 1'b0; msg_en_a = 1'b0; value_a = '0; msg_a = '0;
        load_b = 1'b0; msg_en_b = 1'b0; value_b = '0; msg_b = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        check("rst_ovf", {31'd0, ovf_a}, 32'd0);
        check("rst_bcd", {16'd0, bcd_a}, 32'hFFFF);
        check("rst_an", {28'd0, an_a}, 32'hE);
        check("rst_seg", {25'd0, seg_a}, 32'h7F);
        rst = 1'b0;

        // Scan sequence, each anode held 4 cycles
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
            check("scan_an", {28'd0, an_a}, {28'd0, exp_an});
            check("scan_seg", {25'd0, seg_a}, 32'h7F);
        end

        // Numeric conversions on the 4-digit instance
        do_value(1'b0, 137, 1'b1);
        do_value(1'b0, 0,   1'b0);
        do_value(1'b0, 99,  1'b0);
        do_value(1'b0, 255, 1'b0);

        // Message load: latched at the accepting edge, ready stays high
        msg_en_a = 1'b1; msg_a = 16'hEAAF; load_a = 1'b1;
        @(posedge clk); #1;
        load_a = 1'b0; msg_en_a = 1'b0;
        check("msg_bcd", {16'd0, bcd_a}, 32'hEAAF);
        check("msg_ready", {31'd0, ready_a}, 32'd1);
        check("msg_ovf", {31'd0, ovf_a}, 32'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            waitc = 0;
            while (an_a !== exp_an && waitc < 40) begin
                @(posedge clk); #1;
                waitc++;
            end
            check("msg_an_found", {28'd0, an_a}, {28'd0, exp_an});
            check("msg_seg", {25'd0, seg_a}, {25'd0, seg_ref(msg_a[4*d +: 4])});
        end

        // Overflow on the 2-digit instance, cleared by message and by a fitting value
        do_value(1'b1, 200, 1'b0);
        msg_en_b = 1'b1; msg_b = 8'hDC; load_b = 1'b1;
        @(posedge clk); #1;
        load_b = 1'b0; msg_en_b = 1'b0;
        check("msgb_bcd", {24'd0, bcd_b}, 32'hDC);
        check("msgb_ovf", {31'd0, ovf_b}, 32'd0);
        do_value(1'b1, 200, 1'b0);
        do_value(1'b1, 99,  1'b0);

        // Reset during conversion aborts without commit
        load_a = 1'b1; msg_en_a = 1'b0; value_a = 8'd200;
        @(posedge clk); #1;
        load_a = 1'b0;
        check("abort_busy", {31'd0, ready_a}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        check("abort_bcd", {16'd0, bcd_a}, 32'hFFFF);
        check("abort_ovf", {31'd0, ovf_a}, 32'd0);
        check("abort_an", {28'd0, an_a}, 32'hE);
        check("abort_seg", {25'd0, seg_a}, 32'h7F);
        rst = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        check("abort_nocommit", {16'd0, bcd_a}, 32'hFFFF);
        check("abort_idle", {31'd0, ready_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
